// File: rtl/conv3x3_mac_serial_pkg.sv
// conv3x3_mac_serial_pkg: shared widths, accumulator sizing and FSM states for the serial conv MAC
package conv3x3_mac_serial_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF = 10;
  function automatic int acc_width(input int dw);
    return 2 * dw + 4;
  endfunction
  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_e;
endpackage

// File: rtl/conv3x3_mac_serial_if.sv
// conv3x3_mac_serial_if: window/weight input handshake and result output handshake
interface conv3x3_mac_serial_if
  import conv3x3_mac_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic in_valid, in_ready, relu_en, out_valid, out_ready;
  logic [9*DATA_WIDTH-1:0] pix_flat;
  logic [DATA_WIDTH-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8, bias, out_data;
  modport master (
    output in_valid, pix_flat, w0, w1, w2, w3, w4, w5, w6, w7, w8, bias, relu_en, out_ready,
    input in_ready, out_valid, out_data
  );
  modport slave (
    input in_valid, pix_flat, w0, w1, w2, w3, w4, w5, w6, w7, w8, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv3x3_mac_serial_post.sv
// fx_post_sat: floor shift out the fraction, optional ReLU, saturate accumulator to data width
module fx_post_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 10,
  parameter int ACC_WIDTH = 36
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  input  logic                         relu_en_i,
  output logic        [DATA_WIDTH-1:0] data_o
);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] sh, rl;
  always_comb begin
    sh = acc_i >>> FRAC_BITS;
    rl = (relu_en_i && sh[ACC_WIDTH-1]) ? '0 : sh;
    data_o = rl > MAXV ? MAXV[DATA_WIDTH-1:0] : rl < MINV ? MINV[DATA_WIDTH-1:0] : rl[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/conv3x3_mac_serial.sv
// conv3x3_mac_serial: one 3x3 window x kernel MAC per cycle, then bias/ReLU/saturate into one activation
module conv3x3_mac_serial
  import conv3x3_mac_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_WIDTH = acc_width(DATA_WIDTH)
) (
  input logic clk,
  input logic rst_n,
  conv3x3_mac_serial_if.slave bus
);
  state_e state_q, state_d;
  logic signed [DATA_WIDTH-1:0] pix_q [9];
  logic signed [DATA_WIDTH-1:0] w_q [9];
  logic signed [DATA_WIDTH-1:0] w_in [9];
  logic relu_q, accept;
  logic [3:0] tap_q, tap_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0] out_q, out_d, post;
  assign w_in[0] = bus.w0;
  assign w_in[1] = bus.w1;
  assign w_in[2] = bus.w2;
  assign w_in[3] = bus.w3;
  assign w_in[4] = bus.w4;
  assign w_in[5] = bus.w5;
  assign w_in[6] = bus.w6;
  assign w_in[7] = bus.w7;
  assign w_in[8] = bus.w8;
  assign accept = bus.in_valid && state_q == IDLE;
  assign prod = pix_q[tap_q] * w_q[tap_q];
  assign sum = acc_q + ACC_WIDTH'(prod);
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_data = out_q;
  fx_post_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS(FRAC_BITS),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_post (
    .acc_i(sum),
    .relu_en_i(relu_q),
    .data_o(post)
  );
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    tap_d = tap_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = MAC;
        acc_d = ACC_WIDTH'($signed(bus.bias)) <<< FRAC_BITS;
        tap_d = '0;
      end
      MAC: begin
        acc_d = sum;
        tap_d = tap_q == 4'd8 ? 4'd0 : tap_q + 4'd1;
        if (tap_q == 4'd8) begin
          state_d = HOLD;
          out_d = post;
        end
      end
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      tap_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      tap_q <= tap_d;
      out_q <= out_d;
    end
  // operands are captured at accept so upstream may change them while the MAC runs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) begin
        pix_q[k] <= '0;
        w_q[k] <= '0;
      end
      relu_q <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < 9; k++) begin
        pix_q[k] <= bus.pix_flat[k*DATA_WIDTH +: DATA_WIDTH];
        w_q[k] <= w_in[k];
      end
      relu_q <= bus.relu_en;
    end
endmodule

// File: tb/tb_conv3x3_mac_serial.sv
// tb_conv3x3_mac_serial: table vectors + random vectors through a scoreboard, plus backpressure and reset corners
module tb_conv3x3_mac_serial;
  typedef struct {
    logic [8:0][15:0] pix;
    logic [8:0][15:0] w;
    logic [15:0] bias;
    logic relu;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  vec_t tbl[$];

  conv3x3_mac_serial_if #(.DATA_WIDTH(16)) bus ();
  conv3x3_mac_serial dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] model(input vec_t v);
    longint acc;
    acc = longint'($signed(v.bias)) * 1024;
    for (int k = 0; k < 9; k++) acc += longint'($signed(v.pix[k])) * longint'($signed(v.w[k]));
    acc = acc >>> 10;
    if (v.relu && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic drive(input vec_t v);
    bus.pix_flat = v.pix;
    {bus.w8, bus.w7, bus.w6, bus.w5, bus.w4, bus.w3, bus.w2, bus.w1, bus.w0} = v.w;
    bus.bias = v.bias;
    bus.relu_en = v.relu;
  endtask

  task automatic scramble(input logic keep_valid);
    for (int k = 0; k < 9; k++) bus.pix_flat[k*16 +: 16] = 16'($urandom);
    {bus.w0, bus.w1, bus.w2} = 48'({$urandom, $urandom});
    {bus.w3, bus.w4, bus.w5} = 48'({$urandom, $urandom});
    {bus.w6, bus.w7, bus.w8} = 48'({$urandom, $urandom});
    bus.bias = 16'($urandom);
    bus.relu_en = 1'($urandom);
    bus.in_valid = keep_valid;
  endtask

  task automatic run_vec(input vec_t v, input int hold, input logic keep_valid);
    int n;
    drive(v);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    exp_q.push_back(v.exp);
    #1 scramble(keep_valid);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
      chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
      scramble(keep_valid);
    end
    chk("latency", 32'(n), 32'd9);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 chk("hold_data", 32'(bus.out_data), 32'(v.exp));
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      scramble(keep_valid);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("valid_drop", 32'(bus.out_valid), 32'd0);
    chk("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end

  initial begin
    #500000 $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v, enc1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    enc1.pix = {9{16'h0400}};
    enc1.w = {16'h002d, 16'h01ce, 16'h010c, 16'h004f, 16'h0038, 16'h0097, 16'h0166, 16'h0011, 16'hffe7};
    enc1.bias = 16'hffa2;
    enc1.relu = 1'b0;
    enc1.exp = 16'h0525;
    drive(enc1);
    tbl.push_back(enc1);
    v = enc1; v.pix = '0; v.exp = 16'hffa2; tbl.push_back(v);
    v.relu = 1'b1; v.exp = 16'h0000; tbl.push_back(v);
    v.pix = {9{16'h7fff}}; v.w = {9{16'h7fff}}; v.bias = '0; v.relu = 1'b0; v.exp = 16'h7fff; tbl.push_back(v);
    v.pix = {9{16'h8000}}; v.exp = 16'h8000; tbl.push_back(v);
    v.relu = 1'b1; v.exp = 16'h0000; tbl.push_back(v);
    v.pix = '0; v.w = '0; v.relu = 1'b0; v.pix[4] = 16'h0800; v.w[4] = 16'h0038; v.exp = 16'h0070; tbl.push_back(v);
    v.pix = '0; v.w = '0; v.pix[0] = 16'h0001; v.w[0] = 16'hffff; v.exp = 16'hffff; tbl.push_back(v);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 9; k++) begin
        v.pix[k] = 16'($urandom_range(0, 4095)) - 16'd2048;
        v.w[k] = 16'($urandom_range(0, 1023)) - 16'd512;
      end
      v.bias = 16'($urandom_range(0, 8191)) - 16'd4096;
      v.relu = 1'($urandom);
      v.exp = model(v);
      tbl.push_back(v);
    end
    repeat (2) @(posedge clk);
    #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    foreach (tbl[i]) run_vec(tbl[i], 0, 1'b0);
    run_vec(enc1, 5, 1'b1);
    drive(enc1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = tbl[6];
    run_vec(v, 1, 1'b0);
    run_vec(enc1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv3x3_mac_serial.md
Name: conv3x3_mac_serial

Overview:
- Downstream consumer of the per-layer weight ROMs (w_enc*).
- Takes one 3x3 pixel window and the ROM's nine signed fixed-point weights plus bias.
- Computes one output activation serially: one multiply-accumulate per cycle, then bias, optional ReLU and saturation.
- Sits between the line-buffer/window generator and the feature-map writer of each encoder conv layer.

Parameters:
- DATA_WIDTH, 16, width of pixels, weights, bias and result (signed two's complement, Q6.10 at default).
- FRAC_BITS, 10, fractional bits shared by pixels, weights, bias and result.
- ACC_WIDTH, 36, accumulator width; must be >= 2*DATA_WIDTH+4.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window and weights valid.
- in_ready  out  1  block can accept a window.
- pix_flat  in  9*DATA_WIDTH  window; tap k at bits [k*DATA_WIDTH +: DATA_WIDTH]; tap 0 top-left, row-major.
- w0..w8  in  DATA_WIDTH each  signed kernel weights, tap-aligned with pix_flat.
- bias  in  DATA_WIDTH  signed bias.
- relu_en  in  1  clamp negative results to 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_WIDTH  signed result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset state: state=IDLE, in_ready=1, out_valid=0, out_data=0, acc=0, tap=0.
- FSM states: IDLE, MAC, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch pix_flat, w0..w8, bias and relu_en into internal registers.
  - acc <= sign_extend(bias) <<< FRAC_BITS; tap <= 0; go to MAC.
- MAC: in_ready=0. Each cycle acc <= acc + pix[tap]*w[tap], full 2*DATA_WIDTH signed product, sign-extended to ACC_WIDTH.
  - tap increments 0..8.
  - When tap==8, the final sum (acc + product) is post-processed into out_data, out_valid <= 1, go to HOLD.
- Post-processing, in order:
  - arithmetic shift right by FRAC_BITS (floor, no rounding);
  - if relu_en and value < 0, value = 0;
  - saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Latency: out_valid rises on the 9th rising edge after the accepting edge. Throughput is at most one window per 11 cycles.
- HOLD: out_valid=1. out_data is stable until out_valid&out_ready; then out_valid <= 0 and go to IDLE.
  - No new window is accepted in the handshake cycle (in_ready=0 throughout HOLD).
- Input isolation: changes on pix_flat, weights, bias or relu_en after the accepting edge do not affect the in-flight result.
- in_valid while in_ready=0 is ignored; the upstream must hold it.
- Reset mid-MAC or mid-HOLD: partial result is discarded; outputs return to reset values immediately.
- Overflow: acc never wraps at the default ACC_WIDTH; only the final saturation limits range.

Decomposition:
- Shared package: DATA_WIDTH/FRAC_BITS defaults, ACC_WIDTH formula, state enum (IDLE, MAC, HOLD), saturation limits as constants.
- One natural sub-module: fx_post_sat (combinational shift, ReLU and saturate from ACC_WIDTH to DATA_WIDTH).
  - The next conv and deconv stages reuse it.

Test Plan:
- Enc1 kernel: all pixels 0x0400 (1.0), w0..w8 = ffe7,0011,0166,0097,0038,004f,010c,01ce,002d, bias ffa2, relu_en=0 -> out_data 0x0525, exactly 9 edges after accept.
- Zero window with same weights/bias: relu_en=0 -> 0xffa2; relu_en=1 -> 0x0000.
- Saturation, bias 0:
  - all pixels and weights 0x7fff -> 0x7fff;
  - pixels 0x8000, weights 0x7fff, relu_en=0 -> 0x8000; relu_en=1 -> 0x0000.
- Floor and single tap:
  - pixel4=0x0800, w4=0x0038, all else 0, bias 0 -> 0x0070;
  - pixel0=0x0001, w0=0xffff, all else 0 -> 0xffff.
- Backpressure and isolation: hold out_ready=0 for 5 cycles and scramble all inputs during MAC/HOLD -> out_data stable and correct, in_ready=0, single transfer when out_ready=1, in_ready=1 next cycle.
- Reset during MAC (tap=4) -> out_valid=0, in_ready=1 during reset; next window after release gives the correct result with no residue.
